// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter: FSM encoding, frame
// geometry and the watchdog legality helper.
package uart_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam int DEFAULT_CLK_CY_PER_BIT = 87;
  localparam int UART_FRAME_BITS        = 11;

  // The watchdog must outlast one full frame (start, 8 data, parity, stop).
  function automatic int min_timeout(input int clk_cy_per_bit);
    return UART_FRAME_BITS * clk_cy_per_bit + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin select: first valid request after ptr, wrapping,
// with ptr itself searched last.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_valid
);

  logic [IDW-1:0] cand;

  // Rotating priority search starting one past the last winner.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    cand         = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDW'((int'(ptr) + off) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers: round-robin grant, one-cycle
// strobe, done wait with watchdog, and an inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CLK_CY_PER_BIT = DEFAULT_CLK_CY_PER_BIT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout,
  output logic                       o_Tx_Dv,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < min_timeout(CLK_CY_PER_BIT)) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES shorter than one UART frame");
  end

  logic [1:0]         state;
  logic [IDW-1:0]     ptr;
  logic [WDW-1:0]     wd_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDW-1:0]     grant_idx;
  logic               grant_valid;
  logic               tx_active_unused;

  assign tx_active_unused = i_Tx_Active;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req          (i_req_valid),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  // FSM, capture registers, watchdog and gap counter; all outputs registered.
  // LAUNCH counts as the first watchdog cycle so the abort pulse lands exactly
  // TIMEOUT_CYCLES after the strobe. The IDLE arbitration cycle closes the gap,
  // so GAP itself lasts GAP_CYCLES-1 cycles and the next strobe comes
  // GAP_CYCLES+1 cycles after Done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(NUM_REQ - 1);
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      o_req_ready <= '0;
      o_grant_id  <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_Tx_Dv     <= 1'b0;
      o_Tx_Byte   <= 8'h00;
    end else begin
      o_req_ready <= '0;
      o_Tx_Dv     <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state       <= ST_LAUNCH;
            ptr         <= grant_idx;
            o_grant_id  <= grant_idx;
            o_Tx_Byte   <= i_req_data[{grant_idx, 3'b000} +: 8];
            o_req_ready <= grant_onehot;
            o_Tx_Dv     <= 1'b1;
            o_busy      <= 1'b1;
            wd_cnt      <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          state  <= ST_WAIT_DONE;
          wd_cnt <= wd_cnt + WDW'(1);
        end
        ST_WAIT_DONE: begin
          if (i_Tx_Done) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_GAP;
            gap_cnt   <= '0;
            o_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 2)) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, gap 2,
// watchdog 16) with hand sequences for gap spacing, watchdog, race and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy, timeout, tx_dv, tx_active, tx_done;
  logic [7:0]  tx_byte;

  int n_cmp = 0;
  int n_bad = 0;

  assign tx_active = 1'b0;

  always #5 clk = ~clk;

  initial tx_done = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16), .CLK_CY_PER_BIT(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_grant_id(grant_id), .o_busy(busy),
    .o_timeout(timeout), .o_Tx_Dv(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [1:0]  id;
    logic [7:0]  tx_byte;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'h0;
    tx_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_dv(output int n);
    n = 0;
    while (!tx_dv && n < 20) begin
      step();
      n++;
    end
    if (!tx_dv) n = -1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, t;
    logic acc;
    logic [1:0] rot_exp [6];

    vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h00002211, 4'b0001, 2'd0, 8'h11};
    vecs[2] = '{4'b0011, 32'h00002211, 4'b0010, 2'd1, 8'h22};
    vecs[3] = '{4'b1001, 32'h3C0000C3, 4'b1000, 2'd3, 8'h3C};
    vecs[4] = '{4'b1000, 32'h5A000000, 4'b1000, 2'd3, 8'h5A};
    vecs[5] = '{4'b1111, 32'h44332211, 4'b0001, 2'd0, 8'h11};
    vecs[6] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'hFF};
    rot_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    do_reset();
    step();
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_dv", {31'd0, tx_dv}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_id", {30'd0, grant_id}, 32'd0);
    check("rst_byte", {24'd0, tx_byte}, 32'd0);

    // Simultaneous requesters 0 and 1: 0x11 first, then 0x22 GAP+1 after Done
    req_data = 32'h00002211;
    req_valid = 4'b0011;
    wait_dv(n);
    check("sim_lat0", n, 32'd1);
    check("sim_id0", {30'd0, grant_id}, 32'd0);
    check("sim_byte0", {24'd0, tx_byte}, 32'h11);
    req_valid = 4'b0010;
    repeat (3) step();
    pulse_done();
    wait_dv(n);
    check("sim_spacing", n + 1, 32'd3);
    check("sim_id1", {30'd0, grant_id}, 32'd1);
    check("sim_byte1", {24'd0, tx_byte}, 32'h22);
    req_valid = 4'b0000;
    repeat (3) step();
    pulse_done();
    wait_idle("sim_idle");

    // Rotation with all four continuously valid
    do_reset();
    req_data = 32'h44332211;
    req_valid = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      wait_dv(n);
      check($sformatf("rot%0d_seen", f), {31'd0, n >= 0}, 32'd1);
      check($sformatf("rot%0d_id", f), {30'd0, grant_id}, {30'd0, rot_exp[f]});
      check($sformatf("rot%0d_ready", f), {28'd0, req_ready}, 32'd1 << rot_exp[f]);
      repeat (2) step();
      pulse_done();
    end
    req_valid = 4'b0000;
    wait_idle("rot_idle");

    // Table-driven single frames from IDLE, pointer starting at 3
    do_reset();
    for (int v = 0; v < 7; v++) begin
      req_valid = vecs[v].valid;
      req_data = vecs[v].data;
      step();
      check($sformatf("v%0d_ready", v), {28'd0, req_ready}, {28'd0, vecs[v].ready});
      check($sformatf("v%0d_dv", v), {31'd0, tx_dv}, 32'd1);
      check($sformatf("v%0d_id", v), {30'd0, grant_id}, {30'd0, vecs[v].id});
      check($sformatf("v%0d_byte", v), {24'd0, tx_byte}, {24'd0, vecs[v].tx_byte});
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
      req_valid = 4'b0000;
      req_data = 32'h0;
      repeat (3) step();
      pulse_done();
      check($sformatf("v%0d_busy_gap", v), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_byte_hold", v), {24'd0, tx_byte}, {24'd0, vecs[v].tx_byte});
      repeat (2) step();
      check($sformatf("v%0d_busy_done3", v), {31'd0, busy}, 32'd0);
    end

    // Watchdog: Done never arrives
    req_data = 32'h00000077;
    req_valid = 4'b0001;
    wait_dv(n);
    check("wd_id", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b0000;
    t = 0;
    while (!timeout && t < 40) begin
      step();
      t++;
    end
    check("wd_delay", t, 32'd16);
    check("wd_busy", {31'd0, busy}, 32'd1);
    req_data = 32'h00008800;
    req_valid = 4'b0010;
    wait_dv(n);
    check("wd_next_lat", n, 32'd2);
    check("wd_next_id", {30'd0, grant_id}, 32'd1);
    check("wd_next_byte", {24'd0, tx_byte}, 32'h88);
    req_valid = 4'b0000;
    repeat (2) step();
    pulse_done();
    wait_idle("wd_idle");

    // Done and watchdog expiry in the same cycle: Done wins
    req_data = 32'h00990000;
    req_valid = 4'b0100;
    wait_dv(n);
    check("race_id", {30'd0, grant_id}, 32'd2);
    req_valid = 4'b0000;
    repeat (15) step();
    pulse_done();
    check("race_timeout", {31'd0, timeout}, 32'd0);
    check("race_busy", {31'd0, busy}, 32'd1);
    acc = 1'b0;
    step();
    acc |= timeout;
    step();
    acc |= timeout;
    check("race_busy_done3", {31'd0, busy}, 32'd0);
    step();
    acc |= timeout;
    check("race_no_timeout", {31'd0, acc}, 32'd0);

    // Done while IDLE is ignored
    pulse_done();
    check("idle_done_busy", {31'd0, busy}, 32'd0);
    check("idle_done_dv", {31'd0, tx_dv}, 32'd0);

    // Reset during WAIT_DONE, then pointer restarts at NUM_REQ-1
    req_data = 32'h00005500;
    req_valid = 4'b0010;
    wait_dv(n);
    check("mid_id", {30'd0, grant_id}, 32'd1);
    req_valid = 4'b0000;
    repeat (3) step();
    rst = 1'b1;
    req_data = 32'h77006600;
    req_valid = 4'b1010;
    step();
    check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    check("mid_rst_dv", {31'd0, tx_dv}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    check("mid_rst_id", {30'd0, grant_id}, 32'd0);
    check("mid_rst_byte", {24'd0, tx_byte}, 32'd0);
    rst = 1'b0;
    wait_dv(n);
    check("mid_after_lat", n, 32'd1);
    check("mid_after_id", {30'd0, grant_id}, 32'd1);
    check("mid_after_byte", {24'd0, tx_byte}, 32'h66);
    req_valid = 4'b0000;
    repeat (2) step();
    pulse_done();
    wait_idle("mid_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ byte producers using round-robin arbitration. It accepts one byte per grant and pulses the transmitter's data-valid strobe. It then waits for the transmitter's done pulse and enforces an inter-frame gap before the next grant. A watchdog recovers the controller if done never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle cycles after done or timeout before the next grant; minimum 2, so the transmitter is back in IDLE before the next strobe
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_DONE before abort; must exceed 11*CLK_CY_PER_BIT
CLK_CY_PER_BIT, 87, transmitter bit period; used only for the TIMEOUT_CYCLES legality check

Ports:
i_clk  in  1  clock; one clock domain
i_rst  in  1  reset; synchronous, active-high
i_req_valid  in  NUM_REQ  per-requester byte-valid; held until the matching o_req_ready is seen
i_req_data  in  8*NUM_REQ  requester k byte at bits [8k+7:8k]
o_req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
o_grant_id  out  clog2(NUM_REQ)  index of the requester owning the current frame
o_busy  out  1  high from acceptance until return to IDLE
o_timeout  out  1  one-cycle pulse on watchdog abort
o_Tx_Dv  out  1  strobe to the transmitter
o_Tx_Byte  out  8  byte to the transmitter; stable from LAUNCH until return to IDLE
i_Tx_Active  in  1  transmitter active; status only
i_Tx_Done  in  1  transmitter one-cycle done pulse

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE; all outputs 0; o_Tx_Byte=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - Counters = 0.
  - Reset in any state aborts silently: no ready, no timeout, no Dv.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If any i_req_valid in cycle T, select the first valid index searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Capture that byte and index at T; set ptr to the selected index; go to LAUNCH.
  - If no valid, stay in IDLE.
- LAUNCH (cycle T+1, exactly one cycle):
  - o_Tx_Dv=1 and o_req_ready[k]=1; o_busy=1.
  - Go to WAIT_DONE; clear the watchdog.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On i_Tx_Done=1: go to GAP.
  - Else, when the watchdog reaches TIMEOUT_CYCLES-1: pulse o_timeout, go to GAP.
  - If Done and the timeout fire in the same cycle, Done wins and there is no o_timeout.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE; o_busy drops on entry to IDLE.
  - i_req_valid is ignored during GAP, so the earliest next acceptance is GAP_CYCLES+1 cycles after Done.
- Grant latency: valid to ready/Dv is exactly 1 cycle from IDLE.
- i_Tx_Done outside WAIT_DONE is ignored. A requester dropping valid after capture does not cancel the frame; the captured byte is sent.
- Fairness: after granting k, k has lowest priority. Continuously valid requesters are served in strict rotation.
- Counter widths: clog2(TIMEOUT_CYCLES) and clog2(GAP_CYCLES+1); no wrap is possible.

Decomposition:
- Shared package uart_pkg:
  - arbiter state encoding localparams
  - default CLK_CY_PER_BIT=87
  - UART_FRAME_BITS=11 (start, 8 data, parity, stop)
  - function for the minimum legal TIMEOUT
- Sub-module rr_arbiter: combinational one-hot select from the request vector and pointer, giving grant_onehot and grant_idx. It is reusable for future RX-side sharing.
- Top file holds the FSM, capture registers, watchdog and gap counter. It instantiates rr_arbiter and connects to uart_tx.

Test Plan:
- Single requester: requester 2 is valid with 0xA5 and a Tx model with Done at Dv+957 → ready[2] and Dv one cycle after valid, o_Tx_Byte=0xA5, o_grant_id=2, o_busy low 3 cycles after Done.
- Simultaneous: requesters 0 and 1 valid at once with 0x11 and 0x22 → frame 0x11 then 0x22; second Dv exactly GAP_CYCLES+1 cycles after the first Done.
- Rotation: all 4 continuously valid for 6 frames → grant order 0,1,2,3,0,1.
- Watchdog: TIMEOUT_CYCLES=16 and i_Tx_Done tied 0 → o_timeout pulse exactly 16 cycles after LAUNCH, then GAP and the next grant proceeds.
- Done/timeout race: with TIMEOUT_CYCLES=16, Done is driven on the same cycle the watchdog reaches 15 → no o_timeout, normal GAP.
- Reset mid-frame: assert i_rst during WAIT_DONE → next cycle all outputs are 0 and state is IDLE; with requesters 1 and 3 valid afterwards, requester 1 is granted first (pointer reset).
